axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter BEATS, default 16, beats per write burst (legal 1..16); AXI_awlen SHALL be BEATS-1.
REQ-002 AXI_clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 AXI_rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  burst request from requester 0 / 1.
REQ-005 addr0, addr1  input  32 each  burst start address; sampled only when the grant is issued.
REQ-006 wdata0, wdata1  input  32 each  current beat data from each requester; held stable until the beat is acknowledged.
REQ-007 gnt0, gnt1  output  1 each  requester owns the write port, from grant to burst completion.
REQ-008 ack0, ack1  output  1 each  beat accepted this cycle (combinational).
REQ-009 done0, done1  output  1 each  one-cycle pulse when the burst's write response is received.
REQ-010 err0, err1  output  1 each  sticky write-response error flag.
REQ-011 bcnt0, bcnt1  output  32 each  count of completed bursts per requester.
REQ-012 AXI_awaddr  output  32; AXI_awvalid  output  1; AXI_awready  input  1.
REQ-013 AXI_wdata  output  32; AXI_wvalid  output  1; AXI_wlast  output  1; AXI_wready  input  1.
REQ-014 AXI_bvalid  input  1; AXI_bready  output  1; AXI_bresp  input  2.

Function
REQ-015 The FSM SHALL have four states: IDLE, ADDR, DATA and RESP; only one burst SHALL be outstanding at a time.
REQ-016 IDLE, any req high -> ADDR next cycle; set gnt of the winner; AXI_awaddr <= winner's addr; AXI_awvalid=1. Request-to-awvalid latency SHALL be 1 cycle.
REQ-017 Arbitration SHALL be round-robin: a single request wins; when both request, the requester not granted last wins.
REQ-018 ADDR: AXI_awvalid and AXI_awaddr SHALL be held until AXI_awready=1; on that handshake -> DATA, with AXI_wvalid=1 from the next cycle.
REQ-019 W SHALL NOT start before AW is accepted (no AW/W overlap).
REQ-020 DATA: AXI_wdata SHALL be the granted requester's wdata (mux); AXI_wvalid SHALL stay high; AXI_wlast SHALL be 1 iff beat index = BEATS-1.
REQ-021 A 4-bit beat index, reset to 0 on entering DATA, SHALL increment on each AXI_wvalid & AXI_wready; ackN = AXI_wvalid & AXI_wready & gntN.
REQ-022 The last-beat handshake SHALL move to RESP, AXI_wvalid=0 and AXI_wlast=0 the next cycle.
REQ-023 RESP: AXI_bready=1; on AXI_bvalid -> IDLE next cycle. The FSM SHALL clear gnt, pulse doneN for one cycle and increment bcntN (wrapping at 2^32).
REQ-024 On that response, errN SHALL be set if AXI_bresp[1]=1 (SLVERR or DECERR); OKAY and EXOKAY leave it unchanged.
REQ-025 The last-grant pointer SHALL update at burst completion.
REQ-026 AXI_bready SHALL be 0 outside RESP; AXI_bvalid outside RESP SHALL be ignored.
REQ-027 Deasserting req mid-burst SHALL NOT abort the burst; the burst always completes BEATS beats plus a response.
REQ-028 A new grant SHALL NOT occur in the cycle done pulses; earliest is the cycle after returning to IDLE (awvalid two cycles after bvalid handshake).
REQ-029 Stalls: wready or awready held low indefinitely SHALL hold state and outputs unchanged; no timeout.
REQ-030 gnt0 and gnt1 SHALL never be high simultaneously.

Reset
REQ-031 With AXI_rst_n=0 at a rising edge: state IDLE, beat index 0, last-grant = 1 (requester 0 wins first tie).
REQ-032 Reset SHALL force to 0: gnt0, gnt1, done0, done1, err0, err1, bcnt0, bcnt1.
REQ-033 Reset SHALL force to 0: AXI_awaddr, AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready; AXI_wdata follows its mux.
REQ-034 Reset mid-burst SHALL abandon the transaction immediately, with no completion pulse or count.
REQ-035 Errors SHALL clear only by reset.

Verification
REQ-036 req0=1, addr0=0x1000_0040, awready/wready/bvalid always 1 -> awvalid at +1; 16 beats; wlast on 16th; done0 once; bcnt0=1.
REQ-037 req0=req1=1 continuously from reset -> grants alternate 0,1,0,1; after 4 bursts bcnt0=bcnt1=2; gnt never overlapping.
REQ-038 awready low 5 cycles, wready toggling 1/0 -> awaddr stable while awvalid; exactly 16 acks; wlast only on beat 15; wdata equals granted wdataN each ack.
REQ-039 bresp=2'b10 on burst of requester 1, then 2'b00 -> err1=1 and stays 1; err0=0; done1 pulses both times.
REQ-040 AXI_rst_n=0 during beat 7 of a burst -> next cycle all outputs 0; no done; bcnt unchanged at 0; req0 then wins the first tie.
REQ-041 BEATS=1 build -> wlast on the first beat; awlen=0; full cycle IDLE-ADDR-DATA-RESP-IDLE.

Source files
------------

// File: rtl/axi_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW, W, B) shared between the arbiter and the slave.
// The master modport is the arbiter side; slave is the memory/interconnect side.
interface axi_wr_arbiter_if;
  logic [31:0] AXI_awaddr;
  logic [7:0]  AXI_awlen;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic [31:0] AXI_wdata;
  logic        AXI_wvalid;
  logic        AXI_wlast;
  logic        AXI_wready;
  logic        AXI_bvalid;
  logic        AXI_bready;
  logic [1:0]  AXI_bresp;

  modport master (
    output AXI_awaddr, AXI_awlen, AXI_awvalid,
    input  AXI_awready,
    output AXI_wdata, AXI_wvalid, AXI_wlast,
    input  AXI_wready,
    input  AXI_bvalid, AXI_bresp,
    output AXI_bready
  );

  modport slave (
    input  AXI_awaddr, AXI_awlen, AXI_awvalid,
    output AXI_awready,
    input  AXI_wdata, AXI_wvalid, AXI_wlast,
    output AXI_wready,
    output AXI_bvalid, AXI_bresp,
    input  AXI_bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-requester round-robin arbiter driving one AXI4 write port with fixed-length
// INCR bursts; a single burst is in flight at a time (IDLE -> ADDR -> DATA -> RESP).
module axi_wr_arbiter #(
  parameter int BEATS = 16
) (
  input  logic        AXI_clk,
  input  logic        AXI_rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] bcnt0,
  output logic [31:0] bcnt1,
  axi_wr_arbiter_if.master axi
);

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic [3:0] beat;
  logic       last_gnt;
  logic       win1;
  logic       beat_hs;
  logic       resp_err;

  // last_gnt = 1 means requester 1 owned the previous burst, so requester 0 wins a tie
  always_comb begin
    win1     = req1 && (!req0 || !last_gnt);
    beat_hs  = axi.AXI_wvalid && axi.AXI_wready;
    resp_err = (axi.AXI_bresp == 2'b10) || (axi.AXI_bresp == 2'b11);
  end

  assign ack0          = beat_hs && gnt0;
  assign ack1          = beat_hs && gnt1;
  assign axi.AXI_wdata = gnt1 ? wdata1 : wdata0;
  assign axi.AXI_awlen = 8'(BEATS - 1);

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) begin
      state           <= IDLE;
      beat            <= 4'd0;
      last_gnt        <= 1'b1;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      err0            <= 1'b0;
      err1            <= 1'b0;
      bcnt0           <= 32'd0;
      bcnt1           <= 32'd0;
      axi.AXI_awaddr  <= 32'd0;
      axi.AXI_awvalid <= 1'b0;
      axi.AXI_wvalid  <= 1'b0;
      axi.AXI_wlast   <= 1'b0;
      axi.AXI_bready  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0            <= !win1;
            gnt1            <= win1;
            axi.AXI_awaddr  <= win1 ? addr1 : addr0;
            axi.AXI_awvalid <= 1'b1;
            state           <= ADDR;
          end
        end
        ADDR: begin
          if (axi.AXI_awready) begin
            axi.AXI_awvalid <= 1'b0;
            axi.AXI_wvalid  <= 1'b1;
            axi.AXI_wlast   <= (LAST_BEAT == 4'd0);
            beat            <= 4'd0;
            state           <= DATA;
          end
        end
        DATA: begin
          if (axi.AXI_wready) begin
            if (beat == LAST_BEAT) begin
              axi.AXI_wvalid <= 1'b0;
              axi.AXI_wlast  <= 1'b0;
              axi.AXI_bready <= 1'b1;
              state          <= RESP;
            end else begin
              beat          <= beat + 4'd1;
              axi.AXI_wlast <= ((beat + 4'd1) == LAST_BEAT);
            end
          end
        end
        RESP: begin
          // Completion: release the port, pulse done, count, and record the owner for round-robin
          if (axi.AXI_bvalid) begin
            axi.AXI_bready <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            done0          <= gnt0;
            done1          <= gnt1;
            last_gnt       <= gnt1;
            if (gnt0) begin
              bcnt0 <= bcnt0 + 32'd1;
              err0  <= err0 || resp_err;
            end
            if (gnt1) begin
              bcnt1 <= bcnt1 + 32'd1;
              err1  <= err1 || resp_err;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario and a BEATS=1 build.
module tb_axi_wr_arbiter;
  localparam int BEATS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, done0, done1, err0, err1;
  logic [31:0] bcnt0, bcnt1;

  logic        b_req0;
  logic        b_gnt0, b_gnt1, b_ack0, b_ack1, b_done0, b_done1, b_err0, b_err1;
  logic [31:0] b_bcnt0, b_bcnt1;

  axi_wr_arbiter_if axi ();
  axi_wr_arbiter_if axi1 ();

  axi_wr_arbiter #(.BEATS(BEATS)) dut (
    .AXI_clk(clk), .AXI_rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .bcnt0(bcnt0), .bcnt1(bcnt1), .axi(axi)
  );

  axi_wr_arbiter #(.BEATS(1)) dut1 (
    .AXI_clk(clk), .AXI_rst_n(rst_n),
    .req0(b_req0), .req1(1'b0), .addr0(32'h3000_0000), .addr1(32'h0),
    .wdata0(32'h5555_AAAA), .wdata1(32'h0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .ack0(b_ack0), .ack1(b_ack1),
    .done0(b_done0), .done1(b_done1), .err0(b_err0), .err1(b_err1),
    .bcnt0(b_bcnt0), .bcnt1(b_bcnt1), .axi(axi1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: which requester owns the port and how far the burst has got
  bit          m_busy, m_aw;
  int          m_beats, m_owner;
  logic [31:0] m_addr;
  bit          m_last;
  bit  [1:0]   m_done, m_err;
  logic [31:0] m_bcnt [2];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_aw = 0; m_beats = 0; m_owner = 0; m_addr = '0;
      m_last = 1; m_done = '0; m_err = '0; m_bcnt[0] = '0; m_bcnt[1] = '0;
    end else begin
      m_done = '0;
      if (!m_busy) begin
        if (req0 || req1) begin
          m_owner = (req0 && (!req1 || m_last)) ? 0 : 1;
          m_addr  = (m_owner == 1) ? addr1 : addr0;
          m_busy = 1; m_aw = 0; m_beats = 0;
        end
      end else if (!m_aw) begin
        if (axi.AXI_awready) m_aw = 1;
      end else if (m_beats < BEATS) begin
        if (axi.AXI_wready) m_beats++;
      end else if (axi.AXI_bvalid) begin
        m_busy = 0;
        m_done[m_owner] = 1'b1;
        m_bcnt[m_owner] = m_bcnt[m_owner] + 32'd1;
        if (axi.AXI_bresp[1]) m_err[m_owner] = 1'b1;
        m_last = (m_owner == 1);
      end
    end
  end

  bit chk_en = 0;
  int n_ack0, n_ack1, n_done0, n_done1, ack_idx, n_wlast_ack, wlast_at;
  int gq[$];
  logic prev_g0 = 0, prev_g1 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = m_busy && m_aw && (m_beats < BEATS);
      chk("gnt0", gnt0, m_busy && m_owner == 0);
      chk("gnt1", gnt1, m_busy && m_owner == 1);
      chk("gnt_overlap", gnt0 & gnt1, 1'b0);
      chk("awvalid", axi.AXI_awvalid, m_busy && !m_aw);
      if (m_busy && !m_aw) chk("awaddr", axi.AXI_awaddr, m_addr);
      chk("awlen", axi.AXI_awlen, 32'(BEATS - 1));
      chk("wvalid", axi.AXI_wvalid, ev);
      chk("wlast", axi.AXI_wlast, ev && m_beats == BEATS - 1);
      if (ev) chk("wdata", axi.AXI_wdata, (m_owner == 1) ? wdata1 : wdata0);
      chk("bready", axi.AXI_bready, m_busy && m_aw && m_beats == BEATS);
      chk("ack0", ack0, ev && axi.AXI_wready && m_owner == 0);
      chk("ack1", ack1, ev && axi.AXI_wready && m_owner == 1);
      chk("done0", done0, m_done[0]);
      chk("done1", done1, m_done[1]);
      chk("err0", err0, m_err[0]);
      chk("err1", err1, m_err[1]);
      chk("bcnt0", bcnt0, m_bcnt[0]);
      chk("bcnt1", bcnt1, m_bcnt[1]);
      n_ack0 += int'(ack0); n_ack1 += int'(ack1);
      n_done0 += int'(done0); n_done1 += int'(done1);
      if (ack0 || ack1) begin
        ack_idx++;
        if (axi.AXI_wlast) begin n_wlast_ack++; wlast_at = ack_idx; end
      end
      if (gnt0 && !prev_g0) gq.push_back(0);
      if (gnt1 && !prev_g1) gq.push_back(1);
      prev_g0 = gnt0; prev_g1 = gnt1;
    end
  end

  int cyc = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    wdata0 = 32'hA000_0000 + cyc;
    wdata1 = 32'hB000_0000 + cyc;
  endtask

  task automatic clear_counts();
    n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0;
    ack_idx = 0; n_wlast_ack = 0; wlast_at = 0;
    gq.delete();
  endtask

  task automatic do_reset();
    rst_n = 0; req0 = 0; req1 = 0;
    tick(); tick();
    rst_n = 1;
    clear_counts();
  endtask

  task automatic set_ready(input logic aw, input logic w, input logic b, input logic [1:0] resp);
    axi.AXI_awready = aw; axi.AXI_wready = w; axi.AXI_bvalid = b; axi.AXI_bresp = resp;
  endtask

  // which: 0 done0, 1 done1, 2 done0+done1, 3 ack0
  task automatic wait_for(input int which, input int target, input int budget, input string name);
    int c;
    c = 0;
    for (int i = 0; i < budget; i++) begin
      case (which)
        0: c = n_done0;
        1: c = n_done1;
        2: c = n_done0 + n_done1;
        default: c = n_ack0;
      endcase
      if (c >= target) break;
      tick();
    end
    chk(name, c, target);
  endtask

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; b_req0 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    set_ready(1'b0, 1'b0, 1'b0, 2'b00);
    axi1.AXI_awready = 1'b1; axi1.AXI_wready = 1'b1;
    axi1.AXI_bvalid = 1'b1; axi1.AXI_bresp = 2'b00;
    tick();
    chk_en = 1;
    do_reset();

    // Reset state
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_awvalid", axi.AXI_awvalid, 1'b0);
    chk("rst_bcnt0", bcnt0, 32'd0);

    // BEATS=1 build walks IDLE-ADDR-DATA-RESP-IDLE one cycle each
    chk("b1_awlen", 32'(axi1.AXI_awlen), 32'd0);
    b_req0 = 1; tick(); b_req0 = 0;
    chk("b1_awvalid", axi1.AXI_awvalid, 1'b1);
    chk("b1_awaddr", axi1.AXI_awaddr, 32'h3000_0000);
    tick();
    chk("b1_wvalid", axi1.AXI_wvalid, 1'b1);
    chk("b1_wlast", axi1.AXI_wlast, 1'b1);
    chk("b1_ack0", b_ack0, 1'b1);
    chk("b1_wdata", axi1.AXI_wdata, 32'h5555_AAAA);
    tick();
    chk("b1_bready", axi1.AXI_bready, 1'b1);
    chk("b1_wvalid_off", axi1.AXI_wvalid, 1'b0);
    tick();
    chk("b1_done0", b_done0, 1'b1);
    chk("b1_gnt0_off", b_gnt0, 1'b0);
    chk("b1_bcnt0", b_bcnt0, 32'd1);
    tick();
    chk("b1_done0_pulse", b_done0, 1'b0);
    chk("b1_gnt1", b_gnt1 | b_ack1 | b_done1 | b_err0 | b_err1, 1'b0);
    chk("b1_bcnt1", b_bcnt1, 32'd0);

    // Single requester, all handshakes ready
    set_ready(1'b1, 1'b1, 1'b1, 2'b00);
    addr0 = 32'h1000_0040; req0 = 1;
    tick(); req0 = 0;
    chk("s1_awvalid_lat", axi.AXI_awvalid, 1'b1);
    chk("s1_awaddr", axi.AXI_awaddr, 32'h1000_0040);
    wait_for(0, 1, 40, "s1_done_wait");
    tick();
    chk("s1_acks", n_ack0, 16);
    chk("s1_wlast_cnt", n_wlast_ack, 1);
    chk("s1_wlast_at", wlast_at, 16);
    chk("s1_done0", n_done0, 1);
    chk("s1_bcnt0", bcnt0, 32'd1);

    // Both requesting continuously: strict alternation from requester 0
    do_reset();
    set_ready(1'b1, 1'b1, 1'b1, 2'b00);
    addr1 = 32'h2000_0000; req0 = 1; req1 = 1;
    wait_for(2, 4, 200, "s2_done_wait");
    chk("s2_bcnt0", bcnt0, 32'd2);
    chk("s2_bcnt1", bcnt1, 32'd2);
    req0 = 0; req1 = 0;
    chk("s2_grants", gq.size() >= 4 ? 32'd4 : 32'(gq.size()), 32'd4);
    if (gq.size() >= 4) begin
      chk("s2_g0", gq[0], 0); chk("s2_g1", gq[1], 1);
      chk("s2_g2", gq[2], 0); chk("s2_g3", gq[3], 1);
    end
    tick(); tick();

    // AW stall then W toggling; bvalid held high outside RESP must be ignored
    do_reset();
    set_ready(1'b0, 1'b0, 1'b1, 2'b00);
    addr1 = 32'h2000_0100; req1 = 1;
    tick(); req1 = 0;
    for (int i = 0; i < 5; i++) begin
      chk("s3_awvalid_hold", axi.AXI_awvalid, 1'b1);
      chk("s3_awaddr_hold", axi.AXI_awaddr, 32'h2000_0100);
      tick();
    end
    axi.AXI_awready = 1;
    for (int i = 0; i < 100; i++) begin
      if (n_done1 >= 1) break;
      axi.AXI_wready = ~axi.AXI_wready;
      tick();
    end
    chk("s3_acks", n_ack1, 16);
    chk("s3_wlast_cnt", n_wlast_ack, 1);
    chk("s3_wlast_at", wlast_at, 16);
    chk("s3_done1", n_done1, 1);

    // Error response is sticky on requester 1 only
    do_reset();
    set_ready(1'b1, 1'b1, 1'b1, 2'b10);
    req1 = 1; tick(); req1 = 0;
    wait_for(1, 1, 40, "s4_done_wait1");
    chk("s4_err1_a", err1, 1'b1);
    chk("s4_err0_a", err0, 1'b0);
    axi.AXI_bresp = 2'b00;
    req1 = 1; tick(); req1 = 0;
    wait_for(1, 2, 40, "s4_done_wait2");
    chk("s4_err1_b", err1, 1'b1);
    chk("s4_err0_b", err0, 1'b0);

    // Reset during beat 7 abandons the burst
    do_reset();
    set_ready(1'b1, 1'b1, 1'b1, 2'b00);
    req0 = 1; tick(); req0 = 0;
    wait_for(3, 7, 40, "s5_ack_wait");
    rst_n = 0; req0 = 1; req1 = 1;
    tick();
    chk("s5_gnt", {gnt0, gnt1}, 2'b00);
    chk("s5_awvalid", axi.AXI_awvalid, 1'b0);
    chk("s5_wvalid", axi.AXI_wvalid, 1'b0);
    chk("s5_wlast", axi.AXI_wlast, 1'b0);
    chk("s5_bready", axi.AXI_bready, 1'b0);
    chk("s5_done0", done0, 1'b0);
    chk("s5_bcnt0", bcnt0, 32'd0);
    chk("s5_n_done0", n_done0, 0);
    rst_n = 1;
    tick();
    chk("s5_tie_gnt0", gnt0, 1'b1);
    chk("s5_tie_gnt1", gnt1, 1'b0);
    req0 = 0; req1 = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
